// File: rtl/freq_est.sv
`default_nettype none
// ============================================================================
// Module   : freq_est -- gated edge counter giving an NCO phase increment.
// Revision : 1.0   (define FREQ_EST_AVG_EN to average successive estimates)
// ============================================================================
module freq_est #(
  parameter int PHASE_INC_BITS = 26,
  parameter int GATE_BITS      = 20
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic                      sig_in,
  output logic [PHASE_INC_BITS-1:0] phase_inc,
  output logic                      valid,
  output logic                      ovf
);

  localparam int                   C_SHIFT    = PHASE_INC_BITS - GATE_BITS;
  localparam logic [GATE_BITS-1:0] C_ALL_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [GATE_BITS-1:0]      gate_q, gate_d;
  logic [GATE_BITS-1:0]      cnt_q, cnt_d;
  logic                      sync1_q, sync2_q, prev_q;
  logic [PHASE_INC_BITS-1:0] phase_q, phase_d;
  logic                      valid_q, valid_d;
  logic                      ovf_q, ovf_d;

  logic                      w_edge;
  logic [GATE_BITS-1:0]      w_cnt_inc;
  logic [PHASE_INC_BITS-1:0] w_new_est;
  logic [PHASE_INC_BITS-1:0] w_update;

  assign w_edge    = sync2_q & ~prev_q;
  assign w_cnt_inc = (cnt_q == C_ALL_ONES) ? cnt_q : cnt_q + GATE_BITS'(w_edge);
  assign w_new_est = PHASE_INC_BITS'(cnt_q) << C_SHIFT;

`ifdef FREQ_EST_AVG_EN
  logic [PHASE_INC_BITS-1:0] prev_est_q, prev_est_d;
  logic                      have_prev_q, have_prev_d;

  // Sum is formed one bit wider so the halving never loses the carry.
  assign w_update = have_prev_q
                  ? PHASE_INC_BITS'(({1'b0, w_new_est} + {1'b0, prev_est_q}) >> 1)
                  : w_new_est;
`else
  assign w_update = w_new_est;
`endif

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    valid_d = 1'b0;
`ifdef FREQ_EST_AVG_EN
    prev_est_d  = prev_est_q;
    have_prev_d = have_prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        gate_d = '0;
        cnt_d  = '0;
`ifdef FREQ_EST_AVG_EN
        have_prev_d = 1'b0;
`endif
        if (en) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (!en) begin
          state_d = S_IDLE;
          gate_d  = '0;
          cnt_d   = '0;
        end else begin
          gate_d = gate_q + GATE_BITS'(1);
          cnt_d  = w_cnt_inc;
          if (gate_q == C_ALL_ONES) state_d = S_DONE;
        end
      end
      S_DONE: begin
        phase_d = w_update;
        valid_d = 1'b1;
`ifdef FREQ_EST_AVG_EN
        prev_est_d  = w_new_est;
        have_prev_d = 1'b1;
`endif
        // DONE is cycle 0 of the following window, so its edge opens the new count.
        if (en) begin
          state_d = S_COUNT;
          gate_d  = GATE_BITS'(1);
          cnt_d   = GATE_BITS'(w_edge);
        end else begin
          state_d = S_IDLE;
          gate_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gate_d  = '0;
        cnt_d   = '0;
      end
    endcase
    ovf_d = ovf_q | (cnt_d == C_ALL_ONES);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gate_q  <= '0;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      phase_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      phase_q <= phase_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FREQ_EST_AVG_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_est_q  <= '0;
      have_prev_q <= 1'b0;
    end else begin
      prev_est_q  <= prev_est_d;
      have_prev_q <= have_prev_d;
    end
  end
`endif

  assign phase_inc = phase_q;
  assign valid     = valid_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_est.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_est -- scoreboard bench for freq_est (PHASE_INC_BITS=8, GATE_BITS=6).
// Revision : 1.0
// ============================================================================
module tb_freq_est;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] phase_inc;
  logic       valid;
  logic       ovf;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_valid = 0;
  int         cyc = 0;
  int         gen_per = 0;
  int         gen_ph = 0;
  logic [7:0] sb[$];
  int         valid_cyc[$];

  freq_est #(.PHASE_INC_BITS(8), .GATE_BITS(6)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .sig_in   (sig_in),
    .phase_inc(phase_inc),
    .valid    (valid),
    .ovf      (ovf)
  );

  always #5 CLK = ~CLK;

  // Square-wave source: gen_ph==0 marks the rising half of each period.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (gen_per == 0) begin
        sig_in = 1'b0;
      end else begin
        sig_in = (gen_ph < gen_per / 2);
        gen_ph = (gen_ph + 1) % gen_per;
      end
    end
  end

  // Scoreboard: every valid pulse consumes one expected estimate.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(posedge CLK);
      cyc++;
      #2;
      if (valid === 1'b1) begin
        n_valid++;
        valid_cyc.push_back(cyc);
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid: phase_inc=%0d, no update was expected", phase_inc);
        end else begin
          exp_v = sb.pop_front();
          if (phase_inc !== exp_v) begin
            n_err++;
            $display("FAIL phase_inc: got %0d, expected %0d", phase_inc, exp_v);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    RST = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (phase_inc !== 8'd0) begin n_err++; $display("FAIL reset_phase: got %0d, expected 0", phase_inc); end
    n_cmp++;
    if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", valid); end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b, expected 0", ovf); end
    RST = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_period8();
    int base;
    int k;
    gen_per = 8;
    gen_ph  = 0;
    repeat (10) @(negedge CLK);
    base = n_valid;
    repeat (3) sb.push_back(8'd32);
    en = 1'b1;
    for (int i = 0; i < 300 && n_valid < base + 3; i++) @(negedge CLK);
    en = 1'b0;
    n_cmp++;
    if (n_valid < base + 3) begin
      n_err++;
      $display("FAIL p8_timeout: got %0d valids, expected 3", n_valid - base);
    end else begin
      k = valid_cyc.size();
      n_cmp++;
      if (valid_cyc[k-1] - valid_cyc[k-2] != 64) begin
        n_err++;
        $display("FAIL p8_interval: got %0d cycles, expected 64", valid_cyc[k-1] - valid_cyc[k-2]);
      end
      n_cmp++;
      if (valid_cyc[k-2] - valid_cyc[k-3] != 64) begin
        n_err++;
        $display("FAIL p8_interval: got %0d cycles, expected 64", valid_cyc[k-2] - valid_cyc[k-3]);
      end
    end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL p8_ovf: got %b, expected 0", ovf); end
    repeat (80) @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL p8_pending: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_abandon();
    int base;
    base = n_valid;
    sb.push_back(8'd32);
    en = 1'b1;
    for (int i = 0; i < 200 && n_valid < base + 1; i++) @(negedge CLK);
    repeat (30) @(negedge CLK);
    en = 1'b0;
    repeat (100) @(negedge CLK);
    n_cmp++;
    if (n_valid != base + 1) begin
      n_err++;
      $display("FAIL abandon_valids: got %0d, expected 1", n_valid - base);
    end
    n_cmp++;
    if (phase_inc !== 8'd32) begin n_err++; $display("FAIL abandon_hold: got %0d, expected 32", phase_inc); end
    n_cmp++;
    if (dut.gate_q !== 6'd0) begin n_err++; $display("FAIL abandon_idle_gate: got %0d, expected 0", dut.gate_q); end
    sb.push_back(8'd32);
    en = 1'b1;
    for (int i = 0; i < 200 && n_valid < base + 2; i++) @(negedge CLK);
    en = 1'b0;
    n_cmp++;
    if (n_valid != base + 2) begin
      n_err++;
      $display("FAIL abandon_restart: got %0d valids, expected 2", n_valid - base);
    end
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_ovf();
    int base;
    gen_per = 2;
    gen_ph  = 0;
    repeat (10) @(negedge CLK);
    base = n_valid;
    repeat (2) sb.push_back(8'd128);
    en = 1'b1;
    for (int i = 0; i < 250 && n_valid < base + 2; i++) @(negedge CLK);
    en = 1'b0;
    n_cmp++;
    if (n_valid != base + 2) begin n_err++; $display("FAIL f2_timeout: got %0d valids, expected 2", n_valid - base); end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL f2_ovf: got %b, expected 0", ovf); end
    repeat (5) @(negedge CLK);
    force dut.w_edge = 1'b1;
    sb.push_back(8'd252);
    en = 1'b1;
    for (int i = 0; i < 200 && n_valid < base + 3; i++) @(negedge CLK);
    en = 1'b0;
    release dut.w_edge;
    n_cmp++;
    if (n_valid != base + 3) begin n_err++; $display("FAIL sat_timeout: got %0d valids, expected 3", n_valid - base); end
    n_cmp++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b, expected 1", ovf); end
    gen_per = 8;
    repeat (20) @(negedge CLK);
    sb.push_back(8'd32);
    en = 1'b1;
    for (int i = 0; i < 200 && n_valid < base + 4; i++) @(negedge CLK);
    en = 1'b0;
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, expected 1", ovf); end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL ovf_pending: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_valid;
    sb.push_back(8'd32);
    en = 1'b1;
    for (int i = 0; i < 200 && n_valid < base + 1; i++) @(negedge CLK);
    repeat (40) @(negedge CLK);
    RST = 1'b1;
    en  = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (phase_inc !== 8'd0) begin n_err++; $display("FAIL rstmid_phase: got %0d, expected 0", phase_inc); end
    n_cmp++;
    if (valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b, expected 0", valid); end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf: got %b, expected 0", ovf); end
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    n_cmp++;
    if (n_valid != base + 1) begin n_err++; $display("FAIL rstmid_valids: got %0d, expected 1", n_valid - base); end
  endtask

  task automatic test_avg();
    int base;
    RST = 1'b1;
    en  = 1'b0;
    gen_per = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    base = n_valid;
    sb.push_back(8'd32);
`ifdef FREQ_EST_AVG_EN
    sb.push_back(8'd48);
`else
    sb.push_back(8'd64);
`endif
    sb.push_back(8'd64);
    // Period 8 through the first window, period 4 from its closing edge onward.
    gen_per = 8;
    gen_ph  = 0;
    en      = 1'b1;
    repeat (61) @(negedge CLK);
    gen_per = 4;
    gen_ph  = 3;
    for (int i = 0; i < 300 && n_valid < base + 3; i++) @(negedge CLK);
    en = 1'b0;
    n_cmp++;
    if (n_valid != base + 3) begin n_err++; $display("FAIL avg_timeout: got %0d valids, expected 3", n_valid - base); end
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL avg_pending: got %0d left, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_period8();
    test_abandon();
    test_ovf();
    test_reset_mid();
    test_avg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_est.md
FREQ_EST -- requirements
Module: freq_est

Interface
REQ-001 SHALL have parameter PHASE_INC_BITS, default 26: width of the estimated phase increment, matching the NCO's phase_inc width.
REQ-002 SHALL have parameter GATE_BITS, default 20: measurement window of 2^GATE_BITS clocks; legal range 2 <= GATE_BITS <= PHASE_INC_BITS.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  measurement enable.
REQ-006 SHALL have port sig_in  input  1  asynchronous 1-bit carrier (comparator or square-wave input).
REQ-007 SHALL have port phase_inc  output  PHASE_INC_BITS  latest estimate, registered.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when phase_inc is updated.
REQ-009 SHALL have port ovf  output  1  sticky; set when an edge count saturates.

Function
REQ-010 SHALL pass sig_in through a 2-flop synchronizer, then a 1-flop edge detector.
- A rising edge produces a single-cycle pulse 3 cycles after sig_in rises.
REQ-011 SHALL implement an FSM with three states:
- IDLE: gate counter is 0. Go to COUNT on the first cycle with en=1.
- COUNT: gate counter increments every cycle and the edge counter accumulates. Go to DONE when the gate counter reaches 2^GATE_BITS-1.
- DONE: one cycle. Return to COUNT if en=1, else go to IDLE.
REQ-012 SHALL use an edge counter of GATE_BITS bits that saturates at all-ones, never wrapping; reaching saturation SHALL set ovf.
REQ-013 SHALL count an edge pulse on the final COUNT cycle into the closing window.
- An edge pulse during the DONE cycle SHALL be counted as the first edge of the next window.
- Edges arriving in IDLE SHALL be discarded.
REQ-014 SHALL, in DONE, load phase_inc = edge_count shifted left by (PHASE_INC_BITS-GATE_BITS), zero-filled, and assert valid for exactly that cycle.
REQ-015 SHALL hold phase_inc unchanged between updates.
REQ-016 SHALL, when en falls during COUNT, abandon the window with no valid pulse and enter IDLE next cycle; the partial count SHALL be cleared.
REQ-017 SHALL, when en rises in the same cycle as DONE, restart immediately with no idle gap.
REQ-018 SHALL clear ovf only by RST.

Reset
REQ-019 SHALL, on RST=1 at a rising CLK, clear the FSM to IDLE and clear the gate counter, edge counter, synchronizer, edge detector, phase_inc, valid and ovf.
REQ-020 SHALL give RST priority over en and all in-flight activity; a reset mid-window SHALL discard that window with no valid pulse.
REQ-021 SHALL require at least 3 cycles after reset deassertion before a sig_in edge is guaranteed to be counted.

Configuration
REQ-022 SHALL support macro FREQ_EST_AVG_EN.
- Defined: the DONE update is phase_inc = (new_estimate + previous_estimate) >> 1, computed with one extra bit of width. The first window after reset or after IDLE SHALL use new_estimate alone.
- Undefined: phase_inc = new_estimate (REQ-014) and no previous-estimate register exists.

Verification
REQ-023 SHALL run all scenarios with PHASE_INC_BITS=8, GATE_BITS=6 (64-cycle window, shift 2), macro undefined unless stated.
REQ-024 Test 1: en=1, sig_in period 8 clocks -> valid every 64 cycles, phase_inc=32 (8 edges << 2), ovf=0.
REQ-025 Test 2: en=1, sig_in period 2 clocks (f_clk/2) -> edge count 32, phase_inc=128, ovf=0; then force the edge counter to saturate (63 edges) -> ovf=1 and stays 1 until RST.
REQ-026 Test 3: sig_in period 8, drop en at cycle 30 of a window -> no valid pulse, phase_inc keeps its prior value, FSM in IDLE; re-raise en -> next valid 64 cycles later with phase_inc=32.
REQ-027 Test 4: assert RST at cycle 40 of a window -> phase_inc=0, valid=0, ovf=0 next cycle; no valid pulse for the aborted window.
REQ-028 Test 5: macro FREQ_EST_AVG_EN defined, period 8 for one window then period 4 -> first valid phase_inc=32, second valid phase_inc=(64+32)/2=48, third valid 64.
